// File: rtl/addr_decode_pkg.sv
// Shared definitions for the address decoder: FSM state encoding,
// wait-counter width and the default internal memory map.
package addr_decode_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int WAIT_W = 4;

    localparam logic [31:0] INT_MEM_BASE  = 32'h0000_0800;
    localparam logic [31:0] INT_MEM_LIMIT = 32'h0000_0BFF;

endpackage

// File: rtl/addr_region_match.sv
// Combinational window compare: hit when base <= addr <= limit,
// unsigned over the full address width, both bounds inclusive.
module addr_region_match #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] limit,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit
);

    // Range compare for one window.
    always_comb begin
        hit = (addr >= base) && (addr <= limit);
    end

endmodule

// File: rtl/addr_decode_ctrl.sv
// Programmable address decoder with registered one-hot chip-select and
// per-region wait-state counter.
// Optional build macro ADDR_DECODE_ERR_EN: a miss selects no region and
// completes with an Err pulse instead of using the default external region.
//
// Handshake: Req is sampled only in IDLE; an accepted Req latches the
// decode of Address and the access runs to completion regardless of Req or
// Address afterwards. Ack is a single-cycle pulse in DONE; Busy covers the
// ACCESS and DONE cycles. A new Req is accepted in the IDLE cycle after DONE.
module addr_decode_ctrl
    import addr_decode_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE  = {32'h0000_0C00, INT_MEM_BASE},
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_LIMIT = {32'h0000_0FFF, INT_MEM_LIMIT},
    parameter logic [NUM_REGIONS*WAIT_W-1:0]     REGION_WAIT  = {4'd1, 4'd0},
    parameter logic [WAIT_W-1:0]                 DEFAULT_WAIT = 4'd3
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               Req,
    input  logic [ADDR_WIDTH-1:0]              Address,
    output logic [NUM_REGIONS:0]               Cs,
    output logic [$clog2(NUM_REGIONS+1)-1:0]   RegionIdx,
    output logic                               Busy,
    output logic                               Ack,
    output logic                               Err,
    output logic [ADDR_WIDTH-1:0]              ErrAddr,
    output state_t                             state_dbg
);

    localparam int IDX_W = $clog2(NUM_REGIONS + 1);

    state_t state;
    state_t state_next;

    logic [NUM_REGIONS-1:0] hit;
    logic [NUM_REGIONS:0]   dec_cs;
    logic [IDX_W-1:0]       dec_idx;
    logic [WAIT_W-1:0]      dec_wait;
    logic [WAIT_W-1:0]      wait_cnt;

    genvar g;
    generate
        for (g = 0; g < NUM_REGIONS; g++) begin : g_match
            addr_region_match #(
                .ADDR_WIDTH(ADDR_WIDTH)
            ) u_match (
                .base (REGION_BASE [g*ADDR_WIDTH +: ADDR_WIDTH]),
                .limit(REGION_LIMIT[g*ADDR_WIDTH +: ADDR_WIDTH]),
                .addr (Address),
                .hit  (hit[g])
            );
        end
    endgenerate

    // Priority encode the hits (lowest index wins) into select, index and wait.
    always_comb begin
        dec_cs   = {1'b1, {NUM_REGIONS{1'b0}}};
        dec_idx  = IDX_W'(NUM_REGIONS);
        dec_wait = DEFAULT_WAIT;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_cs    = '0;
                dec_cs[i] = 1'b1;
                dec_idx   = IDX_W'(i);
                dec_wait  = REGION_WAIT[i*WAIT_W +: WAIT_W];
            end
        end
`ifdef ADDR_DECODE_ERR_EN
        if (hit == '0) begin
            dec_cs   = '0;
            dec_wait = '0;
        end
`endif
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Req) state_next = ACCESS;
            ACCESS:  if (wait_cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus the per-access datapath (select, index, wait counter).
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            Cs        <= '0;
            RegionIdx <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (Req) begin
                        Cs        <= dec_cs;
                        RegionIdx <= dec_idx;
                        wait_cnt  <= dec_wait;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                DONE: begin
                    Cs <= '0;
                end
                default: begin
                    Cs <= '0;
                end
            endcase
        end
    end

    assign Busy      = (state != IDLE);
    assign Ack       = (state == DONE);
    assign state_dbg = state;

`ifdef ADDR_DECODE_ERR_EN
    logic                  miss_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    // Remember whether the running access missed, and the address of the last miss.
    always_ff @(posedge CLK) begin
        if (RST) begin
            miss_q     <= 1'b0;
            err_addr_q <= '0;
        end else if (state == IDLE && Req) begin
            miss_q <= (hit == '0);
            if (hit == '0) err_addr_q <= Address;
        end
    end

    assign Err     = Ack & miss_q;
    assign ErrAddr = err_addr_q;
`else
    assign Err     = 1'b0;
    assign ErrAddr = '0;
`endif

endmodule

// File: tb/tb_addr_decode_ctrl.sv
// Directed testbench for addr_decode_ctrl with the default memory map:
// region 0 = 0x800..0xBFF (W=0), region 1 = 0xC00..0xFFF (W=1),
// default external region W=3.
module tb_addr_decode_ctrl;
  import addr_decode_pkg::*;

`ifdef ADDR_DECODE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // clock / reset
  logic        CLK = 1'b0;
  logic        RST;
  logic        Req;
  logic [31:0] Address;
  logic [2:0]  Cs;
  logic [1:0]  RegionIdx;
  logic        Busy;
  logic        Ack;
  logic        Err;
  logic [31:0] ErrAddr;
  state_t      state_dbg;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_err_addr = 32'h0;

  always #5 CLK = ~CLK;

  addr_decode_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .Req      (Req),
    .Address  (Address),
    .Cs       (Cs),
    .RegionIdx(RegionIdx),
    .Busy     (Busy),
    .Ack      (Ack),
    .Err      (Err),
    .ErrAddr  (ErrAddr),
    .state_dbg(state_dbg)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // driver: one isolated access with its hand-derived expected timing
  task automatic run_access(input string tag, input logic [31:0] addr,
                            input logic [2:0] cs_hit, input logic [1:0] idx, input int w);
    logic       miss;
    logic [2:0] exp_cs;
    int         exp_w;
    miss   = (idx == 2'd2);
    exp_cs = (ERR_EN && miss) ? 3'b000 : cs_hit;
    exp_w  = (ERR_EN && miss) ? 0 : w;
    Req     = 1'b1;
    Address = addr;
    step();
    Req = 1'b0;
    if (ERR_EN && miss) exp_err_addr = addr;
    check({tag, " cs"},    32'(Cs),        32'(exp_cs));
    check({tag, " idx"},   32'(RegionIdx), 32'(idx));
    check({tag, " busy"},  32'(Busy),      32'd1);
    check({tag, " ack0"},  32'(Ack),       32'd0);
    check({tag, " state"}, 32'(state_dbg), 32'(ACCESS));
    Address = ~addr;
    for (int k = 0; k < exp_w; k++) begin
      step();
      check({tag, " wait ack"}, 32'(Ack), 32'd0);
      check({tag, " wait cs"},  32'(Cs),  32'(exp_cs));
    end
    step();
    check({tag, " ack"},     32'(Ack),  32'd1);
    check({tag, " ack busy"},32'(Busy), 32'd1);
    check({tag, " ack cs"},  32'(Cs),   32'(exp_cs));
    check({tag, " err"},     32'(Err),  32'(ERR_EN && miss));
    step();
    check({tag, " end ack"},  32'(Ack),       32'd0);
    check({tag, " end busy"}, 32'(Busy),      32'd0);
    check({tag, " end cs"},   32'(Cs),        32'd0);
    check({tag, " end st"},   32'(state_dbg), 32'(IDLE));
    check({tag, " erraddr"},  ErrAddr,        exp_err_addr);
  endtask

  initial begin
    int acks;
    RST     = 1'b1;
    Req     = 1'b0;
    Address = 32'h0;
    step();
    step();
    check("rst cs",      32'(Cs),        32'd0);
    check("rst idx",     32'(RegionIdx), 32'd0);
    check("rst busy",    32'(Busy),      32'd0);
    check("rst ack",     32'(Ack),       32'd0);
    check("rst err",     32'(Err),       32'd0);
    check("rst erraddr", ErrAddr,        32'd0);
    check("rst state",   32'(state_dbg), 32'(IDLE));
    RST = 1'b0;

    // internal hits, window edges and wait states
    run_access("int_lo",  32'h0000_0800, 3'b001, 2'd0, 0);
    run_access("int_hi",  32'h0000_0BFF, 3'b001, 2'd0, 0);
    run_access("reg1_lo", 32'h0000_0C00, 3'b010, 2'd1, 1);
    run_access("reg1_hi", 32'h0000_0FFF, 3'b010, 2'd1, 1);
    run_access("dflt",    32'h0000_1000, 3'b100, 2'd2, 3);
    run_access("below",   32'h0000_07FF, 3'b100, 2'd2, 3);
    run_access("zero",    32'h0000_0000, 3'b100, 2'd2, 3);
    run_access("ones",    32'hFFFF_FFFF, 3'b100, 2'd2, 3);

    // back-to-back with Req held high, address changed mid-access
    Req     = 1'b1;
    Address = 32'h0000_0800;
    step();
    check("b2b first cs", 32'(Cs), 32'b001);
    Address = 32'h0000_1000;
    step();
    check("b2b first ack", 32'(Ack),       32'd1);
    check("b2b hold cs",   32'(Cs),        32'b001);
    check("b2b hold idx",  32'(RegionIdx), 32'd0);
    step();
    check("b2b gap busy", 32'(Busy), 32'd0);
    check("b2b gap cs",   32'(Cs),   32'd0);
    step();
    Req = 1'b0;
    check("b2b second cs",  32'(Cs),        ERR_EN ? 32'd0 : 32'b100);
    check("b2b second idx", 32'(RegionIdx), 32'd2);
    check("b2b second busy",32'(Busy),      32'd1);
    if (ERR_EN) exp_err_addr = 32'h0000_1000;
    acks = 0;
    for (int k = 0; k < 8 && acks == 0; k++) begin
      step();
      if (Ack) acks++;
    end
    check("b2b second ack seen", 32'(acks), 32'd1);
    step();
    check("b2b end busy", 32'(Busy), 32'd0);

    // miss handling, then a later hit must leave the error address alone
    run_access("miss",     32'h0000_1234, 3'b100, 2'd2, 3);
    run_access("hit_after",32'h0000_0800, 3'b001, 2'd0, 0);

    // reset in the middle of an access
    Req     = 1'b1;
    Address = 32'h0000_0900;
    step();
    Req = 1'b0;
    check("mid busy", 32'(Busy), 32'd1);
    RST = 1'b1;
    step();
    check("mid rst cs",    32'(Cs),        32'd0);
    check("mid rst busy",  32'(Busy),      32'd0);
    check("mid rst ack",   32'(Ack),       32'd0);
    check("mid rst state", 32'(state_dbg), 32'(IDLE));
    step();
    RST = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (Ack) acks++;
    end
    check("mid rst no ack", 32'(acks), 32'd0);
    check("mid rst erraddr", ErrAddr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // run-time bound
  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
